// File: rtl/lcd_char_responder.sv
// HD44780-style 8-bit character-LCD device model: synchronises the host bus, executes
// instructions/data against an 80-byte DDRAM, answers reads and mirrors DDRAM for debug.
module lcd_char_responder #(
    parameter int BUSY_SHORT = 4,
    parameter int BUSY_LONG  = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_din,
    output logic [7:0] lcd_dout,
    output logic       lcd_doe,
    input  logic [6:0] dbg_idx,
    output logic [7:0] dbg_char,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic       o_disp_on,
    output logic       o_two_line,
    output logic       o_overrun
);
    localparam int CW       = $clog2(BUSY_LONG + 1);
    localparam int LONG_REM = BUSY_LONG - 80;

    typedef enum logic [1:0] {ST_CLEAR, ST_EXEC, ST_IDLE} state_t;

    logic       e_s1_q, e_s2_q, e_s3_q, rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] din_s1_q, din_s2_q;

    state_t     state_q, state_d;
    logic [6:0] fill_q, fill_d, ac_q, ac_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       id_q, id_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic       n_q, n_d, dl_q, dl_d, f_q, f_d, cg_q, cg_d, overrun_q, overrun_d;

    logic [7:0] mem_q [0:79];
    logic       mem_we;
    logic [6:0] mem_waddr;
    logic [7:0] mem_wdata;

    logic       strobe, go_short;
    logic [6:0] cur_idx;
    logic [7:0] rd_char;
    logic [7:0] d;
    logic       unused_flags;

    // Line 2 (0x40..0x67) sits directly after line 1 in DDRAM when two-line mode is set.
    function automatic logic [6:0] map_idx(input logic [6:0] ac, input logic n);
        if (n && ac >= 7'h40) return ac - 7'd24;
        return ac;
    endfunction

    function automatic logic [6:0] step_ac(input logic [6:0] ac, input logic inc, input logic n);
        if (n) begin
            if (inc) return (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
            return (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
        end
        if (inc) return (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
        return (ac == 7'h00) ? 7'h4F : ac - 7'd1;
    endfunction

    function automatic logic addr_ok(input logic [6:0] a, input logic n);
        if (n) return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
        return a <= 7'h4F;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_s1_q   <= 1'b0;
            e_s2_q   <= 1'b0;
            e_s3_q   <= 1'b0;
            rs_s1_q  <= 1'b0;
            rs_s2_q  <= 1'b0;
            rw_s1_q  <= 1'b0;
            rw_s2_q  <= 1'b0;
            din_s1_q <= 8'h00;
            din_s2_q <= 8'h00;
        end else begin
            e_s1_q   <= lcd_e;
            e_s2_q   <= e_s1_q;
            e_s3_q   <= e_s2_q;
            rs_s1_q  <= lcd_rs;
            rs_s2_q  <= rs_s1_q;
            rw_s1_q  <= lcd_rw;
            rw_s2_q  <= rw_s1_q;
            din_s1_q <= lcd_din;
            din_s2_q <= din_s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            fill_q    <= 7'd0;
            cnt_q     <= '0;
            ac_q      <= 7'd0;
            id_q      <= 1'b1;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            n_q       <= 1'b0;
            dl_q      <= 1'b1;
            f_q       <= 1'b0;
            cg_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            n_q       <= n_d;
            dl_q      <= dl_d;
            f_q       <= f_d;
            cg_q      <= cg_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign strobe  = ~e_s2_q & e_s3_q;
    assign d       = din_s2_q;
    assign cur_idx = map_idx(ac_q, n_q);
    assign rd_char = (cur_idx < 7'd80) ? mem_q[cur_idx] : 8'h20;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        ac_d      = ac_q;
        id_d      = id_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        n_d       = n_q;
        dl_d      = dl_q;
        f_d       = f_q;
        cg_d      = cg_q;
        overrun_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = fill_q;
        mem_wdata = 8'h20;
        go_short  = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                fill_d = fill_q + 7'd1;
                if (fill_q == 7'd79) begin
                    fill_d = 7'd0;
                    if (LONG_REM == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = CW'(LONG_REM);
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q <= CW'(1)) state_d = ST_IDLE;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            default: ;
        endcase

        // Reads go through in any state; only writes can be refused as overruns.
        if (strobe) begin
            if (rw_s2_q) begin
                if (rs_s2_q && state_q == ST_IDLE) ac_d = step_ac(ac_q, id_q, n_q);
            end else if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end else if (rs_s2_q) begin
                if (!cg_q && cur_idx < 7'd80) begin
                    mem_we    = 1'b1;
                    mem_waddr = cur_idx;
                    mem_wdata = d;
                end
                ac_d     = step_ac(ac_q, id_q, n_q);
                go_short = 1'b1;
            end else if (d[7]) begin
                if (addr_ok(d[6:0], n_q)) begin
                    ac_d = d[6:0];
                    cg_d = 1'b0;
                end
                go_short = 1'b1;
            end else if (d[6]) begin
                cg_d     = 1'b1;
                go_short = 1'b1;
            end else if (d[5]) begin
                dl_d     = d[4];
                n_d      = d[3];
                f_d      = d[2];
                go_short = 1'b1;
            end else if (d[4]) begin
                if (!d[3]) ac_d = step_ac(ac_q, d[2], n_q);
                go_short = 1'b1;
            end else if (d[3]) begin
                disp_d   = d[2];
                cur_d    = d[1];
                blink_d  = d[0];
                go_short = 1'b1;
            end else if (d[2]) begin
                id_d     = d[1];
                go_short = 1'b1;
            end else if (d[1]) begin
                ac_d    = 7'd0;
                cg_d    = 1'b0;
                state_d = ST_EXEC;
                cnt_d   = CW'(BUSY_LONG);
            end else if (d[0]) begin
                ac_d    = 7'd0;
                id_d    = 1'b1;
                cg_d    = 1'b0;
                state_d = ST_CLEAR;
                fill_d  = 7'd0;
            end
        end

        if (go_short) begin
            state_d = ST_EXEC;
            cnt_d   = CW'(BUSY_SHORT);
        end
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_ac       = ac_q;
    assign o_disp_on  = disp_q;
    assign o_two_line = n_q;
    assign o_overrun  = overrun_q;
    assign lcd_doe    = e_s2_q & rw_s2_q;
    assign lcd_dout   = !lcd_doe ? 8'h00 :
                        !rs_s2_q ? {o_busy, ac_q} :
                        cg_q     ? 8'h00 : rd_char;
    assign dbg_char   = (dbg_idx < 7'd80) ? mem_q[dbg_idx] : 8'h20;

    // Interface-mode, font and cursor bits are latched for completeness but drive nothing.
    assign unused_flags = ^{dl_q, f_q, cur_q, blink_q};
endmodule
